// File: rtl/bpsk_pkg.sv
// Shared BPSK definitions: receive FSM states, polarity constants common with the
// modulator, and width helpers for the integrate-and-dump datapath.
package bpsk_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    ACQ  = 1'b1
  } state_e;

  // Flag polarity, identical meaning on the modulator side.
  localparam logic FLAG_INVERT = 1'b0;
  localparam logic FLAG_PASS   = 1'b1;

  // One guard bit beyond clog2(SPS) keeps the sum of SPS full-scale samples exact.
  function automatic int acc_width(input int w, input int sps);
    return w + $clog2(sps) + 1;
  endfunction

  // Counter wide enough to hold the value n itself.
  function automatic int cnt_width(input int n);
    return (n < 2) ? 1 : $clog2(n + 1);
  endfunction

endpackage

// File: rtl/bpsk_integrate_dump.sv
// Integrate-and-dump over SPS samples with a sign slicer; emits a bit strobe and
// hard decision combinationally on the sample that closes each bit.
module bpsk_integrate_dump
  import bpsk_pkg::*;
#(
  parameter int SPS = 4,
  parameter int W   = 8
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic [W-1:0] sample_i,
  input  logic         take_i,
  input  logic         restart_i,
  output logic         bit_valid_o,
  output logic         bit_decision_o
);

  localparam int AW = acc_width(W, SPS);
  localparam int CW = cnt_width(SPS);

  logic signed [AW-1:0] acc_q, acc_d, sum_d, sample_ext;
  logic        [CW-1:0] cnt_q, cnt_d, cnt_inc;
  logic                 bit_done;

  assign sample_ext = {{(AW-W){sample_i[W-1]}}, sample_i};

  // A restart discards whatever was integrated and counts this sample as the first.
  always_comb begin
    sum_d    = (restart_i ? '0 : acc_q) + sample_ext;
    cnt_inc  = restart_i ? CW'(1) : cnt_q + CW'(1);
    bit_done = take_i && (cnt_inc == CW'(SPS));
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    if (take_i) begin
      if (bit_done) begin
        acc_d = '0;
        cnt_d = '0;
      end else begin
        acc_d = sum_d;
        cnt_d = cnt_inc;
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      acc_q <= '0;
      cnt_q <= '0;
    end else begin
      acc_q <= acc_d;
      cnt_q <= cnt_d;
    end
  end

  assign bit_valid_o    = bit_done;
  assign bit_decision_o = ~sum_d[AW-1];

endmodule

// File: rtl/bpsk_demodulator.sv
// BPSK receiver: SOF-framed integrate-and-dump, polarity correction with the
// Flag latched at SOF, and MSB-first reassembly of N-bit codewords (N >= 2).
module bpsk_demodulator
  import bpsk_pkg::*;
#(
  parameter int N   = 7,
  parameter int SPS = 4,
  parameter int W   = 8
) (
  input  logic         CLK,
  input  logic         RST,
  input  logic [W-1:0] SampleIn,
  input  logic         SampleValid,
  input  logic         SOF,
  input  logic         Flag,
  output logic [N-1:0] DataOut,
  output logic         DataValid,
  output logic         SyncErr
);

  localparam int BW = cnt_width(N);

  state_e        state_q;
  logic          flag_lat_q;
  logic [BW-1:0] bit_cnt_q;
  logic [N-1:0]  shift_q;
  logic [N-1:0]  data_q;
  logic          data_valid_q;
  logic          sync_err_q;

  logic          start_d, take_d, flag_eff_d, bit_corr_d, word_done_d;
  logic          bit_valid, bit_decision;
  logic [BW-1:0] bit_idx_d;
  logic [N-1:0]  word_d;

  assign start_d = SampleValid && SOF;
  assign take_d  = SampleValid && (start_d || (state_q == ACQ));

  bpsk_integrate_dump #(
    .SPS (SPS),
    .W   (W)
  ) u_integrate_dump (
    .clk_i          (CLK),
    .rst_i          (RST),
    .sample_i       (SampleIn),
    .take_i         (take_d),
    .restart_i      (start_d),
    .bit_valid_o    (bit_valid),
    .bit_decision_o (bit_decision)
  );

  // On an SOF cycle the live Flag applies, so SPS=1 decodes its first bit correctly.
  always_comb begin
    flag_eff_d  = start_d ? Flag : flag_lat_q;
    bit_corr_d  = (flag_eff_d == FLAG_PASS) ? bit_decision : ~bit_decision;
    bit_idx_d   = start_d ? '0 : bit_cnt_q;
    word_d      = {shift_q[N-2:0], bit_corr_d};
    word_done_d = bit_valid && (bit_idx_d == BW'(N - 1));
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q      <= IDLE;
      flag_lat_q   <= FLAG_INVERT;
      bit_cnt_q    <= '0;
      shift_q      <= '0;
      data_q       <= '0;
      data_valid_q <= 1'b0;
      sync_err_q   <= 1'b0;
    end else begin
      data_valid_q <= 1'b0;
      // Any SOF seen while acquiring aborts an unfinished word.
      sync_err_q   <= start_d && (state_q == ACQ);
      if (start_d) begin
        flag_lat_q <= Flag;
      end
      if (bit_valid) begin
        shift_q   <= word_d;
        bit_cnt_q <= bit_idx_d + BW'(1);
      end else if (start_d) begin
        bit_cnt_q <= '0;
      end
      if (word_done_d) begin
        state_q      <= IDLE;
        bit_cnt_q    <= '0;
        data_q       <= word_d;
        data_valid_q <= 1'b1;
      end else if (start_d) begin
        state_q <= ACQ;
      end
    end
  end

  assign DataOut   = data_q;
  assign DataValid = data_valid_q;
  assign SyncErr   = sync_err_q;

endmodule

// File: tb/tb_bpsk_demodulator.sv
// Scoreboard bench for bpsk_demodulator: expected words and SyncErr pulses are
// queued with their due step as stimulus is driven, then checked every cycle.
module tb_bpsk_demodulator;

  localparam int N   = 7;
  localparam int SPS = 4;
  localparam int W   = 8;

  typedef struct {
    logic [N-1:0] word;
    int           due;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [W-1:0] sample_in = '0;
  logic         sample_valid = 1'b0;
  logic         sof = 1'b0;
  logic         flag = 1'b1;
  logic [N-1:0] data_out;
  logic         data_valid;
  logic         sync_err;

  int   total = 0;
  int   bad = 0;
  int   step_idx = 0;
  int   accepted = 0;
  exp_t exp_q[$];
  int   se_q[$];
  int   dv_hist[$];
  int   sq[$];

  always #5 clk = ~clk;

  bpsk_demodulator #(
    .N   (N),
    .SPS (SPS),
    .W   (W)
  ) dut (
    .CLK         (clk),
    .RST         (rst),
    .SampleIn    (sample_in),
    .SampleValid (sample_valid),
    .SOF         (sof),
    .Flag        (flag),
    .DataOut     (data_out),
    .DataValid   (data_valid),
    .SyncErr     (sync_err)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h", tag, got, want);
    end
  endtask

  task automatic observe();
    bit dv_due;
    bit se_due;
    dv_due = (exp_q.size() > 0) && (exp_q[0].due == step_idx);
    se_due = (se_q.size() > 0) && (se_q[0] == step_idx);
    chk("data_valid", {31'd0, data_valid}, {31'd0, dv_due});
    if (dv_due) begin
      chk("data_out", {25'd0, data_out}, {25'd0, exp_q[0].word});
      $display("word step=%0d data_out=%b want=%b", step_idx, data_out, exp_q[0].word);
      void'(exp_q.pop_front());
    end
    if (data_valid) dv_hist.push_back(accepted);
    chk("sync_err", {31'd0, sync_err}, {31'd0, se_due});
    if (se_due) void'(se_q.pop_front());
  endtask

  task automatic step(input logic v, input logic s, input logic [W-1:0] x, input logic f);
    @(negedge clk);
    observe();
    sample_valid = v;
    sof          = s;
    sample_in    = x;
    flag         = f;
    if (v) accepted++;
    step_idx++;
  endtask

  // Drives the samples in sq; SOF on the first, Flag switches to f_mid from sample 8.
  task automatic send(input logic f0, input logic f_mid, input bit gaps, input bit complete,
                      input logic [N-1:0] want, input bit expect_se);
    for (int i = 0; i < sq.size(); i++) begin
      if (gaps && i > 0 && $urandom_range(0, 3) == 0)
        repeat (3) step(1'b0, 1'($urandom_range(0, 1)), W'($urandom), f_mid);
      step(1'b1, i == 0, W'(sq[i]), (i < 8) ? f0 : f_mid);
      if (i == 0 && expect_se) se_q.push_back(step_idx);
      if (complete && i == sq.size() - 1) exp_q.push_back('{want, step_idx});
    end
  endtask

  task automatic build_word(input logic [N-1:0] w);
    sq.delete();
    for (int b = N - 1; b >= 0; b--)
      repeat (SPS) sq.push_back(w[b] ? 100 : -100);
  endtask

  task automatic add4(input int a, input int b, input int c, input int d);
    sq.push_back(a); sq.push_back(b); sq.push_back(c); sq.push_back(d);
  endtask

  initial begin
    logic [N-1:0] wa;
    logic [N-1:0] wb;
    int gap;

    repeat (2) @(negedge clk);
    chk("rst_data_out", {25'd0, data_out}, 32'd0);
    chk("rst_data_valid", {31'd0, data_valid}, 32'd0);
    chk("rst_sync_err", {31'd0, sync_err}, 32'd0);
    rst = 1'b0;

    // Idle with stray samples and an unqualified SOF: nothing must come out.
    step(1'b1, 1'b0, 8'd50, 1'b1);
    step(1'b0, 1'b1, 8'd50, 1'b1);
    step(1'b0, 1'b0, 8'd0, 1'b1);

    build_word(7'b1011001);
    send(1'b1, 1'b1, 1'b0, 1'b1, 7'b1011001, 1'b0);

    build_word(7'b1011001);
    send(1'b0, 1'b1, 1'b0, 1'b1, 7'b0100110, 1'b0);

    // Noisy bit, zero-sum tie, full-scale negative, then 1,0,1,0.
    sq.delete();
    add4(100, -20, -20, -20);
    add4(50, -50, 50, -50);
    add4(-128, -128, -128, -128);
    add4(100, 100, 100, 100);
    add4(-100, -100, -100, -100);
    add4(100, 100, 100, 100);
    add4(-100, -100, -100, -100);
    send(1'b1, 1'b1, 1'b0, 1'b1, 7'b1101010, 1'b0);
    step(1'b0, 1'b0, 8'd0, 1'b1);

    // Resync: abort after 10 samples, then a full word.
    build_word(7'b1110110);
    while (sq.size() > 10) void'(sq.pop_back());
    send(1'b1, 1'b1, 1'b0, 1'b0, '0, 1'b0);
    build_word(7'b0000001);
    send(1'b1, 1'b1, 1'b0, 1'b1, 7'b0000001, 1'b1);
    step(1'b0, 1'b0, 8'd0, 1'b1);

    // Gapped word A followed back-to-back by word B.
    dv_hist.delete();
    wa = N'($urandom);
    wb = N'($urandom_range(1, 127));
    build_word(wa);
    send(1'b1, 1'b1, 1'b1, 1'b1, wa, 1'b0);
    build_word(wb);
    send(1'b0, 1'b0, 1'b0, 1'b1, ~wb, 1'b0);
    repeat (2) step(1'b0, 1'b0, 8'd0, 1'b1);
    gap = (dv_hist.size() >= 2) ? dv_hist[1] - dv_hist[0] : -1;
    chk("b2b_strobes", dv_hist.size(), 32'd2);
    chk("b2b_gap", gap, 32'd28);

    // Asynchronous reset mid-word, then a clean word.
    build_word(7'b1100101);
    while (sq.size() > 15) void'(sq.pop_back());
    send(1'b1, 1'b1, 1'b0, 1'b0, '0, 1'b0);
    @(posedge clk);
    #2;
    rst = 1'b1;
    sample_valid = 1'b0;
    sof = 1'b0;
    #1;
    chk("arst_data_out", {25'd0, data_out}, 32'd0);
    chk("arst_data_valid", {31'd0, data_valid}, 32'd0);
    chk("arst_sync_err", {31'd0, sync_err}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    build_word(7'b0110011);
    send(1'b1, 1'b1, 1'b0, 1'b1, 7'b0110011, 1'b0);

    repeat (3) step(1'b0, 1'b0, 8'd0, 1'b1);
    chk("pending_words", exp_q.size(), 32'd0);
    chk("pending_sync_err", se_q.size(), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/bpsk_demodulator.md
Name: bpsk_demodulator

Overview:
- Receive-side counterpart of the team's BPSK modulator.
- Takes a stream of signed baseband samples and integrates each bit over SPS samples (integrate-and-dump).
- Makes a hard sign decision per bit, undoes the modulator's Flag-controlled inversion, and reassembles N-bit codewords.
- Sits between the channel model / ADC sample path and the Hamming or BCH decoder.

Parameters:
- N, 7, codeword width in bits (7 for Hamming, 15 for BCH).
- SPS, 4, samples per bit; SPS >= 1.
- W, 8, sample width in bits, two's complement.

Ports:
- CLK  input  1  system clock, rising edge.
- RST  input  1  asynchronous, active-high reset.
- SampleIn  input  W  signed baseband sample.
- SampleValid  input  1  SampleIn is valid this cycle.
- SOF  input  1  start of codeword; qualified by SampleValid; marks the first sample of bit N-1.
- Flag  input  1  polarity: 1 = pass decided bits, 0 = invert decided bits. Same meaning as the modulator Flag.
- DataOut  output  N  recovered codeword.
- DataValid  output  1  one-cycle strobe; DataOut is valid.
- SyncErr  output  1  one-cycle strobe; a partial codeword was aborted by SOF.

Behaviour:
- Reset, asynchronous, in any state: DataOut=0, DataValid=0, SyncErr=0, accumulator=0, counters=0, shift register=0, FSM=IDLE.
- Reset mid-word discards the partial word. No output is produced for it.
- Accumulator width is W+clog2(SPS)+1, signed. Every sample is sign-extended before adding, so no overflow is possible. Example: SPS=4, W=8 gives all -128 summing to -512 exactly.
- FSM states: IDLE, ACQ.
- IDLE: ignore samples until SampleValid&&SOF. On that cycle:
  - accumulator <= SampleIn;
  - sample count <= 1; bit count <= 0;
  - latch Flag into FlagLat (Flag is sampled only here);
  - go to ACQ.
- ACQ, each cycle with SampleValid=1 and SOF=0:
  - accumulator += SampleIn; sample count++.
  - On the SPS-th sample of a bit:
    - decision = (acc+SampleIn >= 0) ? 1 : 0. A zero sum decides 1.
    - decided bit = decision XNOR FlagLat.
    - shift the decided bit in so the first-received bit ends up in DataOut[N-1].
    - clear accumulator and sample count; bit count++.
- Codeword complete (SPS-th sample of the N-th bit):
  - next cycle, DataOut <= assembled word and DataValid=1 for exactly one cycle. Latency is 1 clock after the final sample.
  - FSM returns to IDLE. DataOut holds its value until the next completed word.
- SampleValid=0 in ACQ: hold all state. Gaps of any length are allowed.
- SOF asserted in ACQ with SampleValid=1:
  - if the word is incomplete, pulse SyncErr on the next cycle and restart acquisition with this sample as the first sample (same actions as the IDLE start);
  - no DataValid is generated for the aborted word.
- Back-to-back words: SOF on the cycle right after the final sample is accepted from IDLE. There is no dead cycle, and DataValid of the previous word overlaps the first sample of the next.
- SOF on the same cycle as the completing sample is not legal stimulus. Behaviour: treated as a resync, SyncErr pulses and the word is discarded.
- Flag changes mid-word have no effect until the next SOF.
- SOF with SampleValid=0 is ignored.

Decomposition:
- Shared package bpsk_pkg:
  - FSM state enum (IDLE, ACQ);
  - function for accumulator width;
  - polarity constants FLAG_INVERT=0, FLAG_PASS=1, shared with the modulator.
- One sub-module: bpsk_integrate_dump.
  - Contents: accumulator, sample counter, sign slicer.
  - Outputs: bit_valid and bit_decision strobes.
- Top level keeps the FSM, bit counter, shift register, polarity correction and output registers.

Test Plan:
- Default parameters, Flag=1, SOF on the first sample, codeword 1011001 sent as +100/-100 (4 samples per bit, SampleValid=1 continuously) -> DataOut=7'b1011001, DataValid high for one cycle, 1 clock after the 28th sample; SyncErr=0.
- Same stimulus, Flag=0 at SOF, Flag toggled to 1 mid-word -> DataOut=7'b0100110.
- Noisy and tie bits:
  - bit samples {+100,-20,-20,-20} (sum +40) -> bit 1;
  - {+50,-50,+50,-50} (sum 0) -> bit 1;
  - {-128,-128,-128,-128} (sum -512) -> bit 0 with no wraparound.
- Resync: SOF after 10 samples of a word, then a full valid word 0000001 -> one SyncErr pulse, no DataValid for the aborted word, then DataOut=7'b0000001 with one DataValid.
- Gaps and back-to-back: SampleValid deasserted for 3 cycles between random samples of word A, then word B's SOF immediately after A's last sample -> two DataValid strobes with correct words, the second exactly 28 accepted samples after the first.
- Reset mid-word: RST pulsed asynchronously after 15 samples -> outputs 0 immediately, no DataValid; the next SOF-framed word decodes correctly.
